// File: rtl/demux_3outputs_16bits_pipe_if.sv
// ============================================================================
// demux_3outputs_16bits_pipe_if : source and three-channel sink handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface demux_3outputs_16bits_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_select;
  logic [WIDTH-1:0] in_data;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2_data;

  // Producer and consumers of the demux.
  modport master (
    output in_valid, in_select, in_data,
    input  in_ready,
    input  out0_valid, out0_data, out1_valid, out1_data, out2_valid, out2_data,
    output out0_ready, out1_ready, out2_ready
  );

  // The demux itself.
  modport slave (
    input  in_valid, in_select, in_data,
    output in_ready,
    output out0_valid, out0_data, out1_valid, out1_data, out2_valid, out2_data,
    input  out0_ready, out1_ready, out2_ready
  );
endinterface

`default_nettype wire

// File: rtl/demux_3outputs_16bits_pipe.sv
// ============================================================================
// demux_3outputs_16bits_pipe : registered 1-to-3 demux, per-channel valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_3outputs_16bits_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  wire                               clk,
  input  wire                               rst_n,
  demux_3outputs_16bits_pipe_if.slave       bus,
  output logic [CNT_W-1:0]                  drop_count
);

  localparam logic [2:0]       c_sel_ch0 = 3'b000;
  localparam logic [2:0]       c_sel_ch1 = 3'b001;
  localparam logic [2:0]       c_sel_ch2 = 3'b010;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       w_ready;
  logic [2:0]       w_valid;
  logic [2:0]       w_load;
  logic             w_in_ready;
  logic             w_drop;
  logic [WIDTH-1:0] w_data [3];
  logic [CNT_W-1:0] r_drop_count;

  assign w_ready = {bus.out2_ready, bus.out1_ready, bus.out0_ready};

  // in_ready only looks at the targeted slot, so a stalled channel never
  // blocks traffic headed elsewhere; invalid selects are always swallowed.
  always_comb begin
    w_in_ready = 1'b1;
    w_load     = 3'b000;
    w_drop     = 1'b0;
    case (bus.in_select)
      c_sel_ch0: begin
        w_in_ready = !w_valid[0] | w_ready[0];
        w_load[0]  = bus.in_valid & w_in_ready;
      end
      c_sel_ch1: begin
        w_in_ready = !w_valid[1] | w_ready[1];
        w_load[1]  = bus.in_valid & w_in_ready;
      end
      c_sel_ch2: begin
        w_in_ready = !w_valid[2] | w_ready[2];
        w_load[2]  = bus.in_valid & w_in_ready;
      end
      default: begin
        w_drop = bus.in_valid;
      end
    endcase
  end

  assign bus.in_ready = w_in_ready;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_ch
      logic             r_valid;
      logic [WIDTH-1:0] r_data;

      // A load while the word is being consumed gives one-word-per-cycle pass-through.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_load[k]) begin
          r_valid <= 1'b1;
          r_data  <= bus.in_data;
        end else if (w_ready[k]) begin
          r_valid <= 1'b0;
        end
      end

      assign w_valid[k] = r_valid;
      assign w_data[k]  = r_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != c_cnt_max)) begin
      r_drop_count <= r_drop_count + c_cnt_one;
    end
  end

  assign bus.out0_valid = w_valid[0];
  assign bus.out1_valid = w_valid[1];
  assign bus.out2_valid = w_valid[2];
  assign bus.out0_data  = w_data[0];
  assign bus.out1_data  = w_data[1];
  assign bus.out2_data  = w_data[2];
  assign drop_count     = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_demux_3outputs_16bits_pipe.sv
// ============================================================================
// tb_demux_3outputs_16bits_pipe : directed vector bench for the 3-way demux
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_demux_3outputs_16bits_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] drop_count;
  int         checks;
  int         failures;

  demux_3outputs_16bits_pipe_if #(.WIDTH(16)) bus ();

  demux_3outputs_16bits_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [15:0] data;
    logic [2:0]  rdy;   // {out2_ready, out1_ready, out0_ready}
    logic        ir;    // in_ready before the edge
    logic [2:0]  vld;   // {out2_valid, out1_valid, out0_valid} after the edge
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [7:0]  drop;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [15:0] data,
                              input logic [2:0] rdy, input logic ir, input logic [2:0] vld,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [7:0] drop);
    vec_t t;
    t.v = v; t.sel = sel; t.data = data; t.rdy = rdy; t.ir = ir;
    t.vld = vld; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.drop = drop;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check in_ready, clock, check outputs.
  task automatic step(input vec_t t, input string tag);
    bus.in_valid   = t.v;
    bus.in_select  = t.sel;
    bus.in_data    = t.data;
    bus.out0_ready = t.rdy[0];
    bus.out1_ready = t.rdy[1];
    bus.out2_ready = t.rdy[2];
    #1;
    chk({tag, " in_ready"}, {31'd0, bus.in_ready}, {31'd0, t.ir});
    @(posedge clk);
    #1;
    chk({tag, " valids"}, {29'd0, bus.out2_valid, bus.out1_valid, bus.out0_valid}, {29'd0, t.vld});
    if (t.vld[0]) chk({tag, " out0_data"}, {16'd0, bus.out0_data}, {16'd0, t.d0});
    if (t.vld[1]) chk({tag, " out1_data"}, {16'd0, bus.out1_data}, {16'd0, t.d1});
    if (t.vld[2]) chk({tag, " out2_data"}, {16'd0, bus.out2_data}, {16'd0, t.d2});
    chk({tag, " drop_count"}, {24'd0, drop_count}, {24'd0, t.drop});
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " valids"}, {29'd0, bus.out2_valid, bus.out1_valid, bus.out0_valid}, 32'd0);
    chk({tag, " out0_data"}, {16'd0, bus.out0_data}, 32'd0);
    chk({tag, " out1_data"}, {16'd0, bus.out1_data}, 32'd0);
    chk({tag, " out2_data"}, {16'd0, bus.out2_data}, 32'd0);
    chk({tag, " drop_count"}, {24'd0, drop_count}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_select = 3'b000; bus.in_data = 16'h0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl [19];
  vec_t t;
  int   exp_drop;

  initial begin
    checks   = 0;
    failures = 0;

    //          v     sel   data      rdy     ir    vld     d0        d1        d2        drop
    tbl[0]  = mk(1'b1, 3'd1, 16'hBEEF, 3'b111, 1'b1, 3'b010, 16'h0,    16'hBEEF, 16'h0,    8'd0);
    tbl[1]  = mk(1'b0, 3'd0, 16'h0,    3'b111, 1'b1, 3'b000, 16'h0,    16'h0,    16'h0,    8'd0);
    tbl[2]  = mk(1'b1, 3'd0, 16'h1111, 3'b110, 1'b1, 3'b001, 16'h1111, 16'h0,    16'h0,    8'd0);
    tbl[3]  = mk(1'b1, 3'd0, 16'h2222, 3'b110, 1'b0, 3'b001, 16'h1111, 16'h0,    16'h0,    8'd0);
    tbl[4]  = mk(1'b1, 3'd2, 16'h3333, 3'b110, 1'b1, 3'b101, 16'h1111, 16'h0,    16'h3333, 8'd0);
    tbl[5]  = mk(1'b1, 3'd0, 16'h2222, 3'b111, 1'b1, 3'b001, 16'h2222, 16'h0,    16'h0,    8'd0);
    tbl[6]  = mk(1'b0, 3'd0, 16'h0,    3'b111, 1'b1, 3'b000, 16'h0,    16'h0,    16'h0,    8'd0);
    tbl[7]  = mk(1'b1, 3'd3, 16'h7777, 3'b111, 1'b1, 3'b000, 16'h0,    16'h0,    16'h0,    8'd1);
    tbl[8]  = mk(1'b1, 3'd7, 16'h8888, 3'b111, 1'b1, 3'b000, 16'h0,    16'h0,    16'h0,    8'd2);
    tbl[9]  = mk(1'b1, 3'd2, 16'h00A0, 3'b111, 1'b1, 3'b100, 16'h0,    16'h0,    16'h00A0, 8'd2);
    tbl[10] = mk(1'b1, 3'd2, 16'h00A1, 3'b111, 1'b1, 3'b100, 16'h0,    16'h0,    16'h00A1, 8'd2);
    tbl[11] = mk(1'b1, 3'd2, 16'h00A2, 3'b111, 1'b1, 3'b100, 16'h0,    16'h0,    16'h00A2, 8'd2);
    tbl[12] = mk(1'b1, 3'd2, 16'h00A3, 3'b111, 1'b1, 3'b100, 16'h0,    16'h0,    16'h00A3, 8'd2);
    tbl[13] = mk(1'b0, 3'd2, 16'h0,    3'b111, 1'b1, 3'b000, 16'h0,    16'h0,    16'h0,    8'd2);
    tbl[14] = mk(1'b1, 3'd0, 16'h5555, 3'b000, 1'b1, 3'b001, 16'h5555, 16'h0,    16'h0,    8'd2);
    tbl[15] = mk(1'b1, 3'd5, 16'h9999, 3'b000, 1'b1, 3'b001, 16'h5555, 16'h0,    16'h0,    8'd3);
    tbl[16] = mk(1'b0, 3'd0, 16'hDEAD, 3'b000, 1'b0, 3'b001, 16'h5555, 16'h0,    16'h0,    8'd3);
    tbl[17] = mk(1'b1, 3'd1, 16'h6666, 3'b000, 1'b1, 3'b011, 16'h5555, 16'h6666, 16'h0,    8'd3);
    tbl[18] = mk(1'b0, 3'd0, 16'h0,    3'b111, 1'b1, 3'b000, 16'h0,    16'h0,    16'h0,    8'd3);

    do_reset();
    chk_cleared("reset");

    for (int i = 0; i < 19; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Counter saturates at 255 and never wraps.
    exp_drop = 3;
    for (int i = 0; i < 300; i++) begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      t = mk(1'b1, 3'(3 + (i % 5)), 16'(i), 3'b111, 1'b1, 3'b000,
             16'h0, 16'h0, 16'h0, 8'(exp_drop));
      step(t, $sformatf("sat%0d", i));
    end

    // Asynchronous reset with a stalled word and a nonzero counter.
    do_reset();
    chk_cleared("reset2");
    for (int i = 0; i < 5; i++) begin
      t = mk(1'b1, 3'd6, 16'h0, 3'b111, 1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 8'(i + 1));
      step(t, $sformatf("pre%0d", i));
    end
    step(mk(1'b1, 3'd1, 16'hAAAA, 3'b000, 1'b1, 3'b010, 16'h0, 16'hAAAA, 16'h0, 8'd5), "stall1");
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(1'b1, 3'd0, 16'h1234, 3'b111, 1'b1, 3'b001, 16'h1234, 16'h0, 16'h0, 8'd0), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
